// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, prioritised redirects, stall buffering
// and sticky misalignment fault. Define PC_SEQ_EXC_EN to enable exc_req/eret_req/epc.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_br_req,
  input  logic [31:0] i_br_pc4,
  input  logic [15:0] i_br_off,
  input  logic        i_j_req,
  input  logic [31:0] i_j_pc4,
  input  logic [25:0] i_j_idx,
  input  logic        i_jr_req,
  input  logic [31:0] i_jr_addr,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_redirect,
  output logic        o_fault
);

  localparam int unsigned AW = 32;
  localparam int unsigned PW = 3;

  localparam logic [PW-1:0] PRI_NONE = PW'(0);
  localparam logic [PW-1:0] PRI_BR   = PW'(1);
  localparam logic [PW-1:0] PRI_J    = PW'(2);
  localparam logic [PW-1:0] PRI_JR   = PW'(3);
  localparam logic [PW-1:0] PRI_ERET = PW'(4);
  localparam logic [PW-1:0] PRI_EXC  = PW'(5);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_PEND  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_pend_pc;
  logic [PW-1:0] r_pend_pri;
  logic          r_redirect;
  logic          r_fault;

  logic          w_exc;
  logic          w_eret;
  logic [AW-1:0] w_pc4;
  logic [AW-1:0] w_br_tgt;
  logic [AW-1:0] w_j_tgt;
  logic [AW-1:0] w_req_tgt;
  logic [PW-1:0] w_req_pri;
  logic [AW-1:0] w_win_tgt;
  logic [PW-1:0] w_win_pri;
  logic          w_unused_jpc;

`ifdef PC_SEQ_EXC_EN
  assign w_exc  = i_exc_req;
  assign w_eret = i_eret_req;
`else
  logic w_unused_exc;
  assign w_exc        = 1'b0;
  assign w_eret       = 1'b0;
  assign w_unused_exc = &{1'b0, i_exc_req, i_eret_req};
`endif

  assign w_unused_jpc = &{1'b0, i_j_pc4[27:0]};

  assign w_pc4    = r_pc + AW'(4);
  assign w_br_tgt = i_br_pc4 + {{14{i_br_off[15]}}, i_br_off, 2'b00};
  assign w_j_tgt  = {i_j_pc4[31:28], i_j_idx, 2'b00};

  // Highest-priority request of this cycle; lower ones are dropped.
  always_comb begin
    w_req_pri = PRI_NONE;
    w_req_tgt = '0;
    if (w_exc) begin
      w_req_pri = PRI_EXC;
      w_req_tgt = EXC_PC;
    end else if (w_eret) begin
      w_req_pri = PRI_ERET;
      w_req_tgt = i_epc;
    end else if (i_jr_req) begin
      w_req_pri = PRI_JR;
      w_req_tgt = i_jr_addr;
    end else if (i_j_req) begin
      w_req_pri = PRI_J;
      w_req_tgt = w_j_tgt;
    end else if (i_br_req) begin
      w_req_pri = PRI_BR;
      w_req_tgt = w_br_tgt;
    end
  end

  // Pending target only loses to a strictly higher-priority new request.
  always_comb begin
    w_win_pri = r_pend_pri;
    w_win_tgt = r_pend_pc;
    if (w_req_pri > r_pend_pri) begin
      w_win_pri = w_req_pri;
      w_win_tgt = w_req_tgt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_pend_pc  <= '0;
      r_pend_pri <= PRI_NONE;
      r_redirect <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      if (w_exc) begin
        // Exceptions bypass stall, pending and fault.
        r_pend_pri <= PRI_NONE;
        if (EXC_PC[1:0] != 2'b00) begin
          r_fault <= 1'b1;
          r_state <= S_FAULT;
        end else begin
          r_pc       <= EXC_PC;
          r_redirect <= 1'b1;
          r_fault    <= 1'b0;
          r_state    <= S_RUN;
        end
      end else begin
        case (r_state)
          S_FAULT: r_fault <= 1'b1;
          default: begin
            if (i_stall) begin
              if (w_req_pri > r_pend_pri) begin
                r_pend_pc  <= w_req_tgt;
                r_pend_pri <= w_req_pri;
                r_state    <= S_PEND;
              end else if (r_state != S_PEND) begin
                r_state <= S_HOLD;
              end
            end else if (w_win_pri != PRI_NONE) begin
              r_pend_pri <= PRI_NONE;
              if (w_win_tgt[1:0] != 2'b00) begin
                r_fault <= 1'b1;
                r_state <= S_FAULT;
              end else begin
                r_pc       <= w_win_tgt;
                r_redirect <= 1'b1;
                r_state    <= S_RUN;
              end
            end else begin
              r_pc    <= w_pc4;
              r_state <= S_RUN;
            end
          end
        endcase
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_pc4      = w_pc4;
  assign o_redirect = r_redirect;
  assign o_fault    = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random traffic checked
// against a rule-level reference model. Honours PC_SEQ_EXC_EN like the design.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
`ifdef PC_SEQ_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        redirect;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, br_req, j_req, jr_req, exc_req, eret_req;
  logic [31:0] br_pc4, j_pc4, jr_addr, epc;
  logic [15:0] br_off;
  logic [25:0] j_idx;
  logic [31:0] o_pc, o_pc4;
  logic        o_redirect, o_fault;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model state: architectural pc, fault flag, one pending target.
  logic [31:0] m_pc = 32'h0;
  logic        m_fault = 1'b0;
  int          m_pend_pri = 0;
  logic [31:0] m_pend_tgt = 32'h0;

  pc_sequencer #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall),
    .i_br_req(br_req), .i_br_pc4(br_pc4), .i_br_off(br_off),
    .i_j_req(j_req), .i_j_pc4(j_pc4), .i_j_idx(j_idx),
    .i_jr_req(jr_req), .i_jr_addr(jr_addr),
    .i_exc_req(exc_req), .i_eret_req(eret_req), .i_epc(epc),
    .o_pc(o_pc), .o_pc4(o_pc4), .o_redirect(o_redirect), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Rule-level next-state prediction from the current inputs.
  task automatic model_step(output exp_t e);
    int          best_pri;
    logic [31:0] best_tgt;
    e.redirect = 1'b0;
    if (reset) begin
      m_pc = RESET_PC;
      m_fault = 1'b0;
      m_pend_pri = 0;
    end else begin
      best_pri = 0;
      best_tgt = 32'h0;
      if (br_req) begin best_pri = 1; best_tgt = br_pc4 + 32'(int'($signed(br_off))) * 32'd4; end
      if (j_req) begin best_pri = 2; best_tgt = (j_pc4 & 32'hF000_0000) | (32'(j_idx) << 2); end
      if (jr_req) begin best_pri = 3; best_tgt = jr_addr; end
      if (EXC_EN && eret_req) begin best_pri = 4; best_tgt = epc; end
      if (EXC_EN && exc_req) begin
        m_pc = EXC_PC;
        m_fault = 1'b0;
        m_pend_pri = 0;
        e.redirect = 1'b1;
      end else if (m_fault) begin
        m_fault = 1'b1;
      end else if (stall) begin
        if (best_pri > m_pend_pri) begin m_pend_pri = best_pri; m_pend_tgt = best_tgt; end
      end else begin
        if (best_pri > m_pend_pri) begin m_pend_pri = best_pri; m_pend_tgt = best_tgt; end
        if (m_pend_pri != 0) begin
          if (m_pend_tgt[1:0] != 2'b00) m_fault = 1'b1;
          else begin m_pc = m_pend_tgt; e.redirect = 1'b1; end
          m_pend_pri = 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
    e.pc = m_pc;
    e.fault = m_fault;
  endtask

  task automatic clr();
    reset = 1'b0; stall = 1'b0; br_req = 1'b0; j_req = 1'b0; jr_req = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0;
    br_pc4 = 32'h0; br_off = 16'h0; j_pc4 = 32'h0; j_idx = 26'h0; jr_addr = 32'h0; epc = 32'h0;
  endtask

  // Inputs are already driven; predict, queue, and advance one clock.
  task automatic step();
    exp_t e;
    model_step(e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a new pc every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pc", o_pc, e.pc);
        chk("sb_pc4", o_pc4, e.pc + 32'd4);
        chk("sb_redirect", {31'b0, o_redirect}, {31'b0, e.redirect});
        chk("sb_fault", {31'b0, o_fault}, {31'b0, e.fault});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b1;
    step();
    chk("rst_pc", o_pc, 32'h3000);
    chk("rst_redirect", {31'b0, o_redirect}, 32'h0);
    chk("rst_fault", {31'b0, o_fault}, 32'h0);

    clr(); step(); step(); step();
    chk("idle_pc", o_pc, 32'h300C);
    chk("idle_redirect", {31'b0, o_redirect}, 32'h0);

    clr(); br_req = 1'b1; br_pc4 = 32'h3008; br_off = 16'hFFFE; step();
    chk("br_pc", o_pc, 32'h3000);
    chk("br_redirect", {31'b0, o_redirect}, 32'h1);
    clr(); step();
    chk("br_after_pc", o_pc, 32'h3004);
    chk("br_pulse_end", {31'b0, o_redirect}, 32'h0);

    clr(); stall = 1'b1; j_req = 1'b1; j_pc4 = 32'h3010; j_idx = 26'h0000C40; step();
    chk("stall_j_hold", o_pc, 32'h3004);
    clr(); stall = 1'b1; step();
    chk("stall_hold2", o_pc, 32'h3004);
    chk("stall_no_redirect", {31'b0, o_redirect}, 32'h0);
    clr(); step();
    chk("pend_j_pc", o_pc, 32'h3100);
    chk("pend_j_redirect", {31'b0, o_redirect}, 32'h1);

    clr(); jr_req = 1'b1; jr_addr = 32'h5000; br_req = 1'b1; br_pc4 = 32'h3008; step();
    chk("jr_over_br", o_pc, 32'h5000);
    clr(); jr_req = 1'b1; jr_addr = 32'h5002; step();
    chk("misalign_fault", {31'b0, o_fault}, 32'h1);
    chk("misalign_pc", o_pc, 32'h5000);
    clr(); step();
    chk("fault_frozen_pc", o_pc, 32'h5000);
    chk("fault_sticky", {31'b0, o_fault}, 32'h1);

`ifdef PC_SEQ_EXC_EN
    clr(); exc_req = 1'b1; step();
    chk("exc_fault_pc", o_pc, 32'h4180);
    chk("exc_fault_clr", {31'b0, o_fault}, 32'h0);
    clr(); step();
    clr(); stall = 1'b1; br_req = 1'b1; br_pc4 = 32'h3000; step();
    chk("exc_pend_hold", o_pc, 32'h4184);
    clr(); stall = 1'b1; exc_req = 1'b1; step();
    chk("exc_stall_pc", o_pc, 32'h4180);
    clr(); step();
    chk("exc_clears_pend", o_pc, 32'h4184);
    clr(); eret_req = 1'b1; epc = 32'h3020; step();
    chk("eret_pc", o_pc, 32'h3020);
`endif

    clr(); reset = 1'b1; stall = 1'b1; jr_req = 1'b1; jr_addr = 32'h5002; step();
    chk("rst_wins_pc", o_pc, 32'h3000);
    chk("rst_wins_fault", {31'b0, o_fault}, 32'h0);
    clr(); jr_req = 1'b1; jr_addr = 32'hFFFF_FFFC; step();
    chk("wrap_pc4", o_pc4, 32'h0);
    clr(); step();
    chk("wrap_pc", o_pc, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 39) == 0);
      stall    = ($urandom_range(0, 99) < 30);
      br_req   = ($urandom_range(0, 99) < 20);
      j_req    = ($urandom_range(0, 99) < 15);
      jr_req   = ($urandom_range(0, 99) < 12);
      exc_req  = ($urandom_range(0, 99) < 4);
      eret_req = ($urandom_range(0, 99) < 8);
      br_pc4   = $urandom() & 32'hFFFF_FFFC;
      br_off   = 16'($urandom());
      j_pc4    = $urandom();
      j_idx    = 26'($urandom());
      jr_addr  = $urandom();
      epc      = $urandom();
      if ($urandom_range(0, 15) != 0) jr_addr = jr_addr & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) != 0) epc = epc & 32'hFFFF_FFFC;
      step();
    end

    clr(); step();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
